// File: rtl/axi_udp_arp_rx.sv
// axi_udp_arp_rx: decodes ARP frames addressed to this host from an 8-bit stream.
// Optional AXI_UDP_ARP_STATS_EN adds saturating commit/drop counters. Rev 1.0
`default_nettype none

package axi_udp_pkg;
  localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
  localparam logic [15:0] ARP_HW_TYPE      = 16'h0001;
  localparam logic [15:0] ARP_PROTO_TYPE   = 16'h0800;
  localparam logic [7:0]  ARP_HW_SIZE      = 8'd6;
  localparam logic [7:0]  ARP_PROTO_SIZE   = 8'd4;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
  localparam logic [47:0] BROADCAST_MAC    = 48'hffff_ffff_ffff;
endpackage

module axi_udp_arp_rx
  import axi_udp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic        arp_valid,
  input  logic        arp_ready,
  output logic [15:0] arp_oper,
  output logic [47:0] arp_sha,
  output logic [31:0] arp_spa,
  output logic [15:0] stat_rx_arp,
  output logic [15:0] stat_rx_drop
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, TAIL = 2'd2, DROP = 2'd3} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_tready;
  logic        r_dst_loc;
  logic        r_dst_bc;
  logic        r_not_arp;
  logic [15:0] r_oper;
  logic [47:0] r_sha;
  logic [31:0] r_spa;
  logic        r_valid;
  logic [15:0] r_out_oper;
  logic [47:0] r_out_sha;
  logic [31:0] r_out_spa;

  logic        w_beat;
  logic [7:0]  w_mac_byte;
  logic [7:0]  w_ip_byte;
  logic [1:0]  w_ti;
  logic        w_loc;
  logic        w_bc;
  logic        w_et_bad;
  logic        w_not_arp;
  logic        w_fail;
  logic [15:0] w_oper_full;
  logic        w_commit;
  logic        w_drop;
  logic        w_full;
  logic        w_drop_ev;

  always_comb begin
    w_beat      = s_axis_tvalid & s_axis_tready;
    w_mac_byte  = 8'(local_mac >> {3'd5 - r_cnt[2:0], 3'b000});
    // TPA bytes 38..41 map to IP byte 0..3 via the low counter bits
    w_ti        = r_cnt[1:0] - 2'd2;
    w_ip_byte   = 8'(local_ip >> {2'd3 - w_ti, 3'b000});
    w_loc       = ((r_cnt == 6'd0) ? 1'b1 : r_dst_loc) & (s_axis_tdata == w_mac_byte);
    w_bc        = ((r_cnt == 6'd0) ? 1'b1 : r_dst_bc) & (s_axis_tdata == BROADCAST_MAC[7:0]);
    w_et_bad    = ((r_cnt == 6'd12) && (s_axis_tdata != ETHERTYPE_ARP[15:8])) ||
                  ((r_cnt == 6'd13) && (s_axis_tdata != ETHERTYPE_ARP[7:0]));
    w_not_arp   = r_not_arp | w_et_bad;
    w_oper_full = {r_oper[15:8], s_axis_tdata};

    w_fail = 1'b0;
    if (r_cnt <= 6'd5)       w_fail = !(w_loc | w_bc);
    else if (r_cnt == 6'd12 || r_cnt == 6'd13) w_fail = w_et_bad;
    else if (r_cnt == 6'd14) w_fail = (s_axis_tdata != ARP_HW_TYPE[15:8]);
    else if (r_cnt == 6'd15) w_fail = (s_axis_tdata != ARP_HW_TYPE[7:0]);
    else if (r_cnt == 6'd16) w_fail = (s_axis_tdata != ARP_PROTO_TYPE[15:8]);
    else if (r_cnt == 6'd17) w_fail = (s_axis_tdata != ARP_PROTO_TYPE[7:0]);
    else if (r_cnt == 6'd18) w_fail = (s_axis_tdata != ARP_HW_SIZE);
    else if (r_cnt == 6'd19) w_fail = (s_axis_tdata != ARP_PROTO_SIZE);
    else if (r_cnt == 6'd21) w_fail = (w_oper_full != ARP_OPER_REQUEST) &&
                                      (w_oper_full != ARP_OPER_REPLY);
    else if (r_cnt >= 6'd38 && r_cnt <= 6'd41) w_fail = (s_axis_tdata != w_ip_byte);

    // Frame end decisions; non-ARP traffic is silently ignored rather than counted
    w_commit = 1'b0;
    w_drop   = 1'b0;
    if (w_beat && s_axis_tlast) begin
      case (r_state)
        IDLE, HDR: begin
          if (!w_fail && r_cnt == 6'd41) w_commit = 1'b1;
          else if (!w_not_arp)           w_drop   = 1'b1;
        end
        TAIL:    w_commit = 1'b1;
        default: w_drop   = !w_not_arp;
      endcase
    end
    w_full    = r_valid & ~arp_ready;
    w_drop_ev = w_drop | (w_commit & w_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 6'd0;
      r_tready   <= 1'b0;
      r_dst_loc  <= 1'b0;
      r_dst_bc   <= 1'b0;
      r_not_arp  <= 1'b0;
      r_oper     <= 16'd0;
      r_sha      <= 48'd0;
      r_spa      <= 32'd0;
      r_valid    <= 1'b0;
      r_out_oper <= 16'd0;
      r_out_sha  <= 48'd0;
      r_out_spa  <= 32'd0;
    end else begin
      r_tready <= 1'b1;
      if (w_beat) begin
        if (s_axis_tlast)           r_cnt <= 6'd0;
        else if (r_cnt != 6'd42)    r_cnt <= r_cnt + 6'd1;
        r_not_arp <= s_axis_tlast ? 1'b0 : w_not_arp;
        if (r_cnt <= 6'd5) begin
          r_dst_loc <= w_loc;
          r_dst_bc  <= w_bc;
        end
        if (r_cnt == 6'd20) r_oper[15:8] <= s_axis_tdata;
        if (r_cnt == 6'd21) r_oper[7:0]  <= s_axis_tdata;
        if (r_cnt >= 6'd22 && r_cnt <= 6'd27) r_sha <= {r_sha[39:0], s_axis_tdata};
        if (r_cnt >= 6'd28 && r_cnt <= 6'd31) r_spa <= {r_spa[23:0], s_axis_tdata};

        case (r_state)
          IDLE, HDR: begin
            if (s_axis_tlast)          r_state <= IDLE;
            else if (w_fail)           r_state <= DROP;
            else if (r_cnt == 6'd41)   r_state <= TAIL;
            else                       r_state <= HDR;
          end
          default: if (s_axis_tlast)   r_state <= IDLE;
        endcase
      end

      if (w_commit && !w_full) begin
        r_valid    <= 1'b1;
        r_out_oper <= r_oper;
        r_out_sha  <= r_sha;
        r_out_spa  <= r_spa;
      end else if (arp_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign s_axis_tready = r_tready;
  assign arp_valid     = r_valid;
  assign arp_oper      = r_out_oper;
  assign arp_sha       = r_out_sha;
  assign arp_spa       = r_out_spa;

`ifdef AXI_UDP_ARP_STATS_EN
  logic [15:0] r_stat_arp;
  logic [15:0] r_stat_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_arp  <= 16'd0;
      r_stat_drop <= 16'd0;
    end else begin
      if (w_commit && !w_full && r_stat_arp != 16'hffff) r_stat_arp  <= r_stat_arp + 16'd1;
      if (w_drop_ev && r_stat_drop != 16'hffff)          r_stat_drop <= r_stat_drop + 16'd1;
    end
  end

  assign stat_rx_arp  = r_stat_arp;
  assign stat_rx_drop = r_stat_drop;
`else
  logic w_unused;
  assign w_unused     = w_drop_ev;
  assign stat_rx_arp  = 16'd0;
  assign stat_rx_drop = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_udp_arp_rx.sv
// tb_axi_udp_arp_rx: directed frames with a scoreboard of expected decoded ARP records.
`default_nettype none

module tb_axi_udp_arp_rx;

`ifdef AXI_UDP_ARP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [47:0] MAC_L = 48'h02_00_00_00_00_aa;
  localparam logic [47:0] MAC_B = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [31:0] IP_L  = 32'hc0a8_010a;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] local_mac = MAC_L;
  logic [31:0] local_ip  = IP_L;
  logic [7:0]  s_axis_tdata = 8'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        arp_valid;
  logic        arp_ready = 1'b0;
  logic [15:0] arp_oper;
  logic [47:0] arp_sha;
  logic [31:0] arp_spa;
  logic [15:0] stat_rx_arp;
  logic [15:0] stat_rx_drop;

  axi_udp_arp_rx dut (
    .clk(clk), .rst(rst), .local_mac(local_mac), .local_ip(local_ip),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .arp_valid(arp_valid), .arp_ready(arp_ready), .arp_oper(arp_oper),
    .arp_sha(arp_sha), .arp_spa(arp_spa),
    .stat_rx_arp(stat_rx_arp), .stat_rx_drop(stat_rx_drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_arp  = 0;
  int exp_drop = 0;
  logic [7:0]  fr [0:63];
  int          flen;
  logic [95:0] sb [$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_arp"},  96'(stat_rx_arp),  STATS ? 96'(exp_arp)  : 96'd0);
    chk({tag, "_drop"}, 96'(stat_rx_drop), STATS ? 96'(exp_drop) : 96'd0);
  endtask

  task automatic check_out(input string tag);
    logic [95:0] e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(tag, {arp_oper, arp_sha, arp_spa}, e);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] oper,
                       input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                       input int len);
    logic [47:0] src;
    src = 48'h02_00_00_00_00_99;
    for (int i = 0; i < 64; i++) fr[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fr[i]    = dst[47-8*i -: 8];
      fr[6+i]  = src[47-8*i -: 8];
      fr[22+i] = sha[47-8*i -: 8];
    end
    fr[12] = etype[15:8]; fr[13] = etype[7:0];
    fr[14] = 8'h00; fr[15] = 8'h01; fr[16] = 8'h08; fr[17] = 8'h00;
    fr[18] = 8'h06; fr[19] = 8'h04;
    fr[20] = oper[15:8]; fr[21] = oper[7:0];
    for (int i = 0; i < 4; i++) begin
      fr[28+i] = spa[31-8*i -: 8];
      fr[38+i] = tpa[31-8*i -: 8];
    end
    flen = len;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    @(posedge clk); #1;
  endtask

  task automatic send(input bit rdy_on_last);
    for (int i = 0; i < flen; i++) begin
      if (i == flen - 1 && rdy_on_last) arp_ready = 1'b1;
      beat(fr[i], i == flen - 1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    arp_ready     = 1'b0;
  endtask

  task automatic handshake(input string tag);
    arp_ready = 1'b1;
    @(posedge clk); #1;
    arp_ready = 1'b0;
    chk({tag, "_valid_fall"}, 96'(arp_valid), 96'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 96'(s_axis_tready), 96'd0);
    chk("rst_valid",  96'(arp_valid), 96'd0);
    chk("rst_fields", {arp_oper, arp_sha, arp_spa}, 96'd0);
    chk("rst_stat_arp",  96'(stat_rx_arp),  96'd0);
    chk("rst_stat_drop", 96'(stat_rx_drop), 96'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("tready_up", 96'(s_axis_tready), 96'd1);

    // Broadcast request for us, 60 bytes
    build(MAC_B, 16'h0806, 16'h0001, 48'h02_00_00_00_00_01, 32'hc0a8_0101, IP_L, 60);
    sb.push_back({16'h0001, 48'h02_00_00_00_00_01, 32'hc0a8_0101});
    for (int i = 0; i < flen - 1; i++) beat(fr[i], 1'b0);
    chk("t1_valid_pre", 96'(arp_valid), 96'd0);
    beat(fr[flen-1], 1'b1);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("t1_valid", 96'(arp_valid), 96'd1);
    check_out("t1_fields");
    exp_arp++;
    handshake("t1");
    chk_stats("t1");

    // Wrong TPA
    build(MAC_B, 16'h0806, 16'h0001, 48'h02_00_00_00_00_01, 32'hc0a8_0101, 32'hc0a8_010b, 60);
    send(1'b0);
    chk("t2_valid", 96'(arp_valid), 96'd0);
    exp_drop++;
    chk_stats("t2");

    // Back-to-back, output register held full
    build(MAC_B, 16'h0806, 16'h0001, 48'h02_00_00_00_00_02, 32'hc0a8_0102, IP_L, 60);
    sb.push_back({16'h0001, 48'h02_00_00_00_00_02, 32'hc0a8_0102});
    send(1'b0);
    chk("t3a_valid", 96'(arp_valid), 96'd1);
    check_out("t3a_fields");
    exp_arp++;
    build(MAC_L, 16'h0806, 16'h0002, 48'h02_00_00_00_00_03, 32'hc0a8_0103, IP_L, 60);
    send(1'b0);
    chk("t3b_valid", 96'(arp_valid), 96'd1);
    chk("t3b_held", {arp_oper, arp_sha, arp_spa}, {16'h0001, 48'h02_00_00_00_00_02, 32'hc0a8_0102});
    exp_drop++;
    handshake("t3");
    chk_stats("t3");

    // Short frame (tlast at byte 30), then a valid unicast reply
    build(MAC_L, 16'h0806, 16'h0001, 48'h02_00_00_00_00_04, 32'hc0a8_0104, IP_L, 31);
    send(1'b0);
    chk("t4_short_valid", 96'(arp_valid), 96'd0);
    exp_drop++;
    build(MAC_L, 16'h0806, 16'h0002, 48'h02_00_00_00_00_05, 32'hc0a8_0105, IP_L, 60);
    sb.push_back({16'h0002, 48'h02_00_00_00_00_05, 32'hc0a8_0105});
    send(1'b0);
    chk("t4_valid", 96'(arp_valid), 96'd1);
    check_out("t4_fields");
    exp_arp++;
    handshake("t4");
    chk_stats("t4");

    // 42-byte frames; second commits in the same cycle as the handshake
    build(MAC_B, 16'h0806, 16'h0001, 48'h02_00_00_00_00_06, 32'hc0a8_0106, IP_L, 42);
    sb.push_back({16'h0001, 48'h02_00_00_00_00_06, 32'hc0a8_0106});
    send(1'b0);
    chk("t5a_valid", 96'(arp_valid), 96'd1);
    check_out("t5a_fields");
    build(MAC_B, 16'h0806, 16'h0002, 48'h02_00_00_00_00_07, 32'hc0a8_0107, IP_L, 42);
    sb.push_back({16'h0002, 48'h02_00_00_00_00_07, 32'hc0a8_0107});
    send(1'b1);
    chk("t5b_valid", 96'(arp_valid), 96'd1);
    check_out("t5b_fields");
    exp_arp += 2;
    handshake("t5");
    chk_stats("t5");

    // IPv4 frame is ignored entirely
    build(MAC_L, 16'h0800, 16'h0001, 48'h02_00_00_00_00_08, 32'hc0a8_0108, IP_L, 60);
    send(1'b0);
    chk("t6_valid", 96'(arp_valid), 96'd0);
    chk_stats("t6");

    // Reset in the middle of an ARP frame, then a fresh valid frame
    build(MAC_B, 16'h0806, 16'h0001, 48'h02_00_00_00_00_09, 32'hc0a8_0109, IP_L, 60);
    for (int i = 0; i < 25; i++) beat(fr[i], 1'b0);
    s_axis_tdata = fr[25];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_arp = 0; exp_drop = 0;
    chk("t7_rst_valid", 96'(arp_valid), 96'd0);
    chk_stats("t7_rst");
    @(posedge clk); #1;
    build(MAC_B, 16'h0806, 16'h0001, 48'h02_00_00_00_00_0a, 32'hc0a8_010c, IP_L, 60);
    sb.push_back({16'h0001, 48'h02_00_00_00_00_0a, 32'hc0a8_010c});
    send(1'b0);
    chk("t7_valid", 96'(arp_valid), 96'd1);
    check_out("t7_fields");
    exp_arp++;
    handshake("t7");
    repeat (3) @(posedge clk);
    #1;
    chk("t7_no_extra", 96'(arp_valid), 96'd0);
    chk_stats("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
